dff_counter_timer_ctrl: RTL and testbench
=========================================

// Module: dff_counter_timer_ctrl
// PURPOSE
//   Sequencer for the dff-built synchronous up counter: start/stop control, prescaled
//   count enable, programmable terminal value, one-shot or periodic operation.
//   Sits between a register/control interface and the counter datapath.
//   Produces a terminal-count pulse and a completion strobe for downstream logic.
// PARAMETERS
//   WIDTH      4  counter width in bits (count, limit)
//   PRESC_W    4  prescaler width in bits; tick period = presc+1 clocks
// PORTS
//   clk       in   1        single clock; all state updates on posedge
//   rst       in   1        asynchronous, active-high reset
//   start     in   1        level-sampled request; accepted only in IDLE
//   stop      in   1        abort; returns to IDLE, no tc/done generated
//   mode      in   1        0 = one-shot, 1 = periodic; captured at start
//   limit     in   WIDTH    terminal count value; captured at start
//   presc     in   PRESC_W  prescaler reload; captured at start
//   count     out  WIDTH    current counter value
//   busy      out  1        high in LOAD and RUN
//   tc_pulse  out  1        one-cycle pulse on the tick where count == limit
//   done      out  1        one-cycle strobe when a one-shot run completes
// BEHAVIOUR
//   Reset (async, any state): state=IDLE, count=0, prescaler=0, captured regs=0,
//     busy=0, tc_pulse=0, done=0. Deassertion mid-run: restart from IDLE.
//   States: IDLE, LOAD, RUN, DONE.
//   IDLE: start=1 & stop=0 -> capture mode/limit/presc, go LOAD. start&stop -> stay IDLE.
//   LOAD: one cycle; count<=0, prescaler<=0; -> RUN (stop -> IDLE).
//   RUN: prescaler increments each clock; tick when prescaler==presc_q, prescaler<=0.
//     On tick: count<limit_q -> count+1.
//              count==limit_q -> tc_pulse=1 next cycle (registered);
//                periodic: count<=0, stay RUN; one-shot: count holds limit_q, -> DONE.
//   DONE: done=1 for exactly one cycle, busy=0; -> IDLE. count holds until next start.
//   stop in LOAD/RUN: -> IDLE next edge, count frozen, stop beats tick in same cycle.
//   start while busy or in DONE: ignored (no queuing).
//   Latency: start sampled at edge E -> LOAD after E, RUN after E+1, first increment
//     at edge E+2+presc. With presc=0, count advances every clock in RUN.
//   limit=0: every tick is terminal; periodic gives tc_pulse every presc+1 clocks.
//   limit=2^WIDTH-1: full range, no overflow past limit (compare precedes increment).
//   Arithmetic: unsigned, WIDTH bits; prescaler compare unsigned, PRESC_W bits.
// STRUCTURE
//   Package dff_counter_timer_pkg: state enum (IDLE/LOAD/RUN/DONE), MODE_ONESHOT=0,
//     MODE_PERIODIC=1 constants.
//   Sub-module dff_up_counter_en: WIDTH-bit counter from per-bit D stages,
//     d[i] = q[i] ^ (en & &q[i-1:0]), plus sync clear and async rst.
//     Controller drives en (tick & ~terminal) and clr (LOAD or periodic wrap).
//   Controller: FSM + prescaler + capture regs + registered tc_pulse/done.
// TESTING
//   1. Reset mid-RUN (count=5) -> next cycle count=0, busy=0, state IDLE, no tc/done.
//   2. One-shot, limit=3, presc=0: start -> count 0,1,2,3 on consecutive RUN cycles,
//      tc_pulse once, done once, count holds 3, busy low after DONE.
//   3. Periodic, limit=2, presc=2: count steps every 3 clocks 0,1,2,0,...; tc_pulse
//      every 9 clocks; done never asserts.
//   4. Full range limit=15, presc=0, periodic: 0..15 then wrap to 0, tc_pulse at 15.
//   5. stop on same cycle as tick at count=4 -> count stays 4, IDLE, no tc_pulse.
//   6. start while busy and start&stop in IDLE -> both ignored; captured limit unchanged.

Source files
------------

// File: rtl/dff_counter_timer_pkg.sv
// dff_counter_timer_pkg: shared state codes and mode constants for the counter/timer sequencer
package dff_counter_timer_pkg;
    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t LOAD = 2'd1;
    localparam state_t RUN  = 2'd2;
    localparam state_t DONE = 2'd3;
    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;
endpackage

// File: rtl/dff_up_counter_en.sv
// dff_up_counter_en: up counter built from per-bit toggle D stages with enable and sync clear
module dff_up_counter_en #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] w_t;
    logic [WIDTH-1:0] w_d;
    assign w_t[0] = en;
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i > 0) begin : g_carry
            assign w_t[i] = w_t[i-1] & q[i-1];
        end
        assign w_d[i] = q[i] ^ w_t[i];
    end
    // bit i toggles when enabled and all lower bits are one; clear wins over counting
    always_ff @(posedge clk or posedge rst)
        if (rst) q <= '0;
        else     q <= clr ? '0 : w_d;
endmodule

// File: rtl/dff_counter_timer_ctrl.sv
// dff_counter_timer_ctrl: start/stop sequencer with prescaled tick, terminal compare and one-shot/periodic modes
module dff_counter_timer_ctrl
    import dff_counter_timer_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int PRESC_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic [WIDTH-1:0]   limit,
    input  logic [PRESC_W-1:0] presc,
    output logic [WIDTH-1:0]   count,
    output logic               busy,
    output logic               tc_pulse,
    output logic               done
);
    state_t               r_state;
    state_t               w_next;
    logic                 r_mode_q;
    logic [WIDTH-1:0]     r_limit_q;
    logic [PRESC_W-1:0]   r_presc_q;
    logic [PRESC_W-1:0]   r_pre;
    logic                 r_tc;
    logic                 w_run;
    logic                 w_tick;
    logic                 w_term;
    logic                 w_go;
    logic                 w_accept;
    logic                 w_en;
    logic                 w_clr;

    assign w_run    = r_state == RUN;
    assign w_tick   = w_run & (r_pre == r_presc_q);
    assign w_term   = count == r_limit_q;
    // stop suppresses any tick landing on the same edge
    assign w_go     = w_tick & ~stop;
    assign w_accept = (r_state == IDLE) & start & ~stop;
    assign w_en     = w_go & ~w_term;
    assign w_clr    = ((r_state == LOAD) & ~stop) | (w_go & w_term & (r_mode_q == MODE_PERIODIC));
    assign busy     = (r_state == LOAD) | w_run;
    assign done     = r_state == DONE;
    assign tc_pulse = r_tc;

    dff_up_counter_en #(.WIDTH(WIDTH)) u_cnt (
        .clk (clk),
        .rst (rst),
        .en  (w_en),
        .clr (w_clr),
        .q   (count)
    );

    // next-state selection; one-shot leaves RUN on its terminal tick
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_accept ? LOAD : IDLE;
            LOAD:    w_next = stop ? IDLE : RUN;
            RUN:     w_next = stop ? IDLE : (w_go & w_term & (r_mode_q == MODE_ONESHOT)) ? DONE : RUN;
            default: w_next = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or posedge rst)
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;

    // run parameters are frozen at the accepted start
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_mode_q  <= MODE_ONESHOT;
            r_limit_q <= '0;
            r_presc_q <= '0;
        end else if (w_accept) begin
            r_mode_q  <= mode;
            r_limit_q <= limit;
            r_presc_q <= presc;
        end

    // prescaler: cleared in LOAD, counts in RUN, wraps on tick, holds on stop
    always_ff @(posedge clk or posedge rst)
        if (rst)                    r_pre <= '0;
        else if (r_state == LOAD)   r_pre <= '0;
        else if (w_run & ~stop)     r_pre <= w_tick ? '0 : r_pre + PRESC_W'(1);

    // terminal pulse appears the cycle after the terminal tick
    always_ff @(posedge clk or posedge rst)
        if (rst) r_tc <= 1'b0;
        else     r_tc <= w_go & w_term;
endmodule

// File: tb/tb_dff_counter_timer_ctrl.sv
// tb_dff_counter_timer_ctrl: directed and random stimulus checked against an elapsed-time reference model
module tb_dff_counter_timer_ctrl;
    localparam int W  = 4;
    localparam int PW = 4;
    localparam int P_IDLE = 0, P_LOAD = 1, P_RUN = 2, P_DONE = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          mode = 1'b0;
    logic [W-1:0]  limit = '0;
    logic [PW-1:0] presc = '0;
    logic [W-1:0]  count;
    logic          busy;
    logic          tc_pulse;
    logic          done;

    int n_chk = 0;
    int n_fail = 0;
    int m_ph = P_IDLE;
    int m_k = 0;
    int m_L = 0;
    int m_P = 0;
    int m_M = 0;
    int m_cnt = 0;
    bit m_tc = 0;

    always #5 clk = ~clk;

    dff_counter_timer_ctrl #(.WIDTH(W), .PRESC_W(PW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .mode     (mode),
        .limit    (limit),
        .presc    (presc),
        .count    (count),
        .busy     (busy),
        .tc_pulse (tc_pulse),
        .done     (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // reference: count derived from clocks elapsed in RUN divided by the tick period
    task automatic model(input bit st, input bit sp);
        int t;
        m_tc = 0;
        case (m_ph)
            P_IDLE: if (st && !sp) begin
                m_L = int'(limit); m_P = int'(presc); m_M = int'(mode); m_ph = P_LOAD;
            end
            P_LOAD: if (sp) m_ph = P_IDLE;
                    else begin m_ph = P_RUN; m_k = 0; m_cnt = 0; end
            P_RUN: if (sp) m_ph = P_IDLE;
                   else begin
                       m_k++;
                       if (m_k % (m_P + 1) == 0) begin
                           t = m_k / (m_P + 1);
                           if (m_M == 1) begin
                               m_cnt = t % (m_L + 1);
                               m_tc  = (t % (m_L + 1)) == 0;
                           end else if (t > m_L) begin
                               m_tc = 1; m_ph = P_DONE;
                           end else m_cnt = t;
                       end
                   end
            default: m_ph = P_IDLE;
        endcase
    endtask

    task automatic cyc(input bit st, input bit sp);
        @(negedge clk);
        start = st;
        stop  = sp;
        @(posedge clk);
        model(st, sp);
        #1;
        chk("count", count, m_cnt);
        chk("busy", busy, m_ph == P_LOAD || m_ph == P_RUN);
        chk("tc_pulse", tc_pulse, m_tc);
        chk("done", done, m_ph == P_DONE);
    endtask

    task automatic do_reset();
        @(negedge clk);
        start = 0;
        stop  = 0;
        rst   = 1;
        #1;
        chk("rst_count", count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tc", tc_pulse, 0);
        chk("rst_done", done, 0);
        m_ph = P_IDLE; m_cnt = 0; m_tc = 0;
        @(negedge clk);
        rst = 0;
    endtask

    task automatic setup(input bit md, input int lm, input int ps);
        mode = md; limit = W'(lm); presc = PW'(ps);
    endtask

    initial begin
        do_reset();
        // mid-run reset at count 5
        setup(0, 10, 0);
        cyc(1, 0);
        for (int i = 0; i < 20 && !(m_ph == P_RUN && m_cnt == 5); i++) cyc(0, 0);
        chk("t1_reach", count, 5);
        do_reset();
        cyc(0, 0);
        // one-shot limit 3, presc 0
        setup(0, 3, 0);
        cyc(1, 0);
        for (int i = 0; i < 10; i++) cyc(0, 0);
        // periodic limit 2, presc 2
        setup(1, 2, 2);
        cyc(1, 0);
        for (int i = 0; i < 30; i++) cyc(0, 0);
        cyc(0, 1);
        // periodic full range
        setup(1, 15, 0);
        cyc(1, 0);
        for (int i = 0; i < 40; i++) cyc(0, 0);
        cyc(0, 1);
        cyc(0, 0);
        // stop on the tick that would leave count 4
        setup(0, 10, 1);
        cyc(1, 0);
        for (int i = 0; i < 40 && !(m_ph == P_RUN && m_cnt == 4 && (m_k + 1) % (m_P + 1) == 0); i++) cyc(0, 0);
        chk("t5_reach", count, 4);
        cyc(0, 1);
        cyc(0, 0);
        // start held while busy with new limit applied; then start&stop in idle
        setup(0, 5, 1);
        cyc(1, 0);
        limit = 2;
        for (int i = 0; i < 14; i++) cyc(1, 0);
        cyc(0, 1);
        cyc(1, 1);
        cyc(1, 1);
        cyc(0, 0);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0)
                setup(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
            if ($urandom_range(0, 499) == 0) do_reset();
            else cyc(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 39) == 0));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
